mdr_mem_if: RTL
===============

// Module: mdr_mem_if
// PURPOSE
//  Parametrised memory data register with its own memory-handshake engine.
//  Loads from the internal bus (BusMuxOut) or from memory on a Read command.
//  Drives memory writes with byte enables; supports byte/half/word/dword sizes,
//  sign/zero extension and an ack timeout. Sits between the datapath bus and RAM.
// PARAMETERS
//  DATA_W    32  register/memory data width; 32 or 64 only
//  ADDR_W    9   memory address width
//  MAX_WAIT  15  cycles mem_req may stay high without mem_ack before timeout (>=1)
// PORTS
//  clock      in   1          rising-edge clock
//  reset_n    in   1          asynchronous, active-low reset
//  BusMuxOut  in   DATA_W     internal bus data
//  MDRin      in   1          load Q from BusMuxOut (IDLE only)
//  Read       in   1          start memory read into Q (1-cycle pulse)
//  Write      in   1          start memory write of Q (1-cycle pulse)
//  addr       in   ADDR_W     byte address, sampled with Read/Write
//  size       in   2          00 byte, 01 half, 10 word, 11 dword
//  sign_ext   in   1          1: sign-extend loaded data; 0: zero-extend
//  mem_req    out  1          memory request, held until ack or timeout
//  mem_we     out  1          1 write, 0 read; valid while mem_req
//  mem_addr   out  ADDR_W     latched address, lane bits cleared
//  mem_be     out  DATA_W/8   byte enables (writes); all-ones on reads
//  mem_wdata  out  DATA_W     Q replicated across lanes for the access size
//  mem_rdata  in   DATA_W     read data, sampled on mem_ack
//  mem_ack    in   1          memory completion; ignored unless mem_req=1
//  Q          out  DATA_W     register contents
//  busy       out  1          1 in RD or WR
//  done       out  1          1-cycle pulse after successful completion
//  err        out  1          1-cycle pulse: illegal command, misalignment, timeout
// BEHAVIOUR
//  - Reset (async, reset_n=0): Q=0, state=IDLE, mem_req=mem_we=0, mem_addr=0,
//    mem_be=0, mem_wdata=0, busy=done=err=0, wait counter=0. Mid-op reset aborts the
//    access; mem_req falls immediately, without waiting for a clock edge.
//  - All outputs are registered. States: IDLE, RD, WR.
//  - IDLE, edge with Read^Write=1: check command. Illegal if size=11 with DATA_W=32,
//    or misaligned (half: addr[0]!=0; word: addr[1:0]!=0; dword: addr[2:0]!=0).
//    Illegal -> err=1 next cycle, stay IDLE, Q unchanged, no request.
//    Legal -> latch addr/size/sign_ext; enter RD (Read) or WR (Write); mem_req=1 next cycle.
//  - IDLE, Read&Write both 1 -> err pulse, no operation.
//  - IDLE, MDRin=1 with no Read/Write: Q<=BusMuxOut. Read/Write in the same cycle take
//    priority; MDRin is ignored.
//  - MDRin/Read/Write in RD or WR are ignored (no queueing).
//  - RD: on an edge with mem_ack=1, select lane = mem_rdata >> (8*addr low bits).
//    Q <= lane extended to DATA_W (sign_ext picks MSB of the accessed size). Next
//    cycle: done=1, mem_req=0, IDLE.
//  - WR: mem_wdata = Q low bytes of the access size, replicated into every lane.
//    mem_be = size mask shifted by addr low bits. On ack: done=1, mem_req=0, IDLE;
//    Q unchanged.
//  - Latency: command at edge N -> mem_req high from N+1. Ack sampled at edge N+k ->
//    done high in cycle N+k+1. Minimum total 2 cycles (ack in the first req cycle).
//  - Timeout: the counter increments each req cycle without ack. If it reaches MAX_WAIT
//    without ack -> err=1, mem_req=0, IDLE, Q unchanged. An ack arriving on the
//    MAX_WAIT-th cycle counts as success.
//  - done and err are never high together; busy = (state!=IDLE).
// TESTING
//  1 MDRin=1, BusMuxOut=32'hDEADBEEF -> Q=32'hDEADBEEF next edge; no mem_req.
//  2 Read, addr=9'h003, size=00, sign_ext=1, ack after 3 cycles with rdata=32'h80xxxxxx
//    -> Q=32'hFFFFFF80, done 1 cycle, busy 4 cycles.
//  3 Q=32'h0000ABCD, Write addr=9'h002 size=01 -> mem_wdata=32'hABCDABCD,
//    mem_be=4'b1100, mem_addr=9'h000; ack -> done.
//  4 Read addr=9'h001 size=10 -> err pulse, no mem_req; Read+Write together -> err.
//  5 Read with no ack, MAX_WAIT=15 -> mem_req high exactly 15 cycles, then err, Q unchanged.
//  6 reset_n low during RD -> mem_req=0 with no clock edge, Q=0; Read after release works.

Source files
------------

// File: rtl/mdr_mem_if_if.sv
// rtl/mdr_mem_if_if.sv - memory-side handshake bundle for the memory data register
interface mdr_mem_if_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mdr_mem_if.sv
// rtl/mdr_mem_if.sv - memory data register with sized read/write handshake and ack timeout
module mdr_mem_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  mdr_mem_if_if.master      mem,
  output logic [DATA_W-1:0] Q,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int  BE_W     = DATA_W / 8;
  localparam int  OFF_W    = $clog2(BE_W);
  localparam int  CNT_W    = $clog2(MAX_WAIT + 1);
  localparam bit  NO_DWORD = (DATA_W == 32);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t             state;
  logic [OFF_W-1:0]   off_q;
  logic [1:0]         size_q;
  logic               sext_q;
  logic [CNT_W-1:0]   wait_cnt;

  logic               cmd_illegal;
  logic [OFF_W-1:0]   cmd_off;
  logic [2:0]         lane_mask;
  logic [BE_W-1:0]    wr_be_base;
  logic [BE_W-1:0]    wr_be;
  logic [DATA_W-1:0]  wr_data;
  logic [DATA_W-1:0]  rd_lane;
  logic [DATA_W-1:0]  rd_ext;

  assign cmd_off = addr[OFF_W-1:0];
  assign busy    = (state != IDLE);

  // Command check and write-lane preparation, evaluated from the live command inputs
  always_comb begin
    cmd_illegal = 1'b0;
    lane_mask   = 3'd0;
    wr_be_base  = '0;
    wr_data     = '0;
    unique case (size)
      2'd0: begin lane_mask = 3'd0; wr_be_base = BE_W'(1); end
      2'd1: begin lane_mask = 3'd1; wr_be_base = BE_W'(3);  cmd_illegal = addr[0]; end
      2'd2: begin lane_mask = 3'd3; wr_be_base = BE_W'(15); cmd_illegal = |addr[1:0]; end
      2'd3: begin lane_mask = 3'd7; wr_be_base = '1;        cmd_illegal = NO_DWORD | (|addr[2:0]); end
    endcase
    wr_be = wr_be_base << cmd_off;
    for (int i = 0; i < BE_W; i++) begin
      wr_data[8*i +: 8] = Q[8*(i & int'(lane_mask) & (BE_W-1)) +: 8];
    end
  end

  always_comb begin
    rd_lane = mem.mem_rdata >> {off_q, 3'b000};
    rd_ext  = rd_lane;
    unique case (size_q)
      2'd0: rd_ext = sext_q ? DATA_W'($signed(rd_lane[7:0]))  : DATA_W'(rd_lane[7:0]);
      2'd1: rd_ext = sext_q ? DATA_W'($signed(rd_lane[15:0])) : DATA_W'(rd_lane[15:0]);
      2'd2: rd_ext = sext_q ? DATA_W'($signed(rd_lane[31:0])) : DATA_W'(rd_lane[31:0]);
      2'd3: rd_ext = rd_lane;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      Q             <= '0;
      off_q         <= '0;
      size_q        <= '0;
      sext_q        <= 1'b0;
      wait_cnt      <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= '0;
      mem.mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Read ^ Write) begin
            if (cmd_illegal) begin
              err <= 1'b1;
            end else begin
              state         <= Read ? RD : WR;
              off_q         <= cmd_off;
              size_q        <= size;
              sext_q        <= sign_ext;
              wait_cnt      <= '0;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= Write;
              mem.mem_addr  <= addr & ~ADDR_W'(BE_W - 1);
              mem.mem_be    <= Write ? wr_be : '1;
              mem.mem_wdata <= Write ? wr_data : '0;
            end
          end else if (Read & Write) begin
            err <= 1'b1;
          end else if (MDRin) begin
            Q <= BusMuxOut;
          end
        end
        RD, WR: begin
          // An ack on the last allowed cycle still wins over the timeout
          if (mem.mem_ack) begin
            if (state == RD) Q <= rd_ext;
            done        <= 1'b1;
            state       <= IDLE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            wait_cnt    <= '0;
          end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            err         <= 1'b1;
            state       <= IDLE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
